// File: rtl/johnson_seq_monitor_if.sv
// Handshake bundle between a Johnson code source and the sequence monitor.
// master drives the samples and the error-clear; slave is the monitor.
interface johnson_seq_monitor_if #(
    parameter int WIDTH    = 5,
    parameter int IDX_W    = 4,
    parameter int ERRCNT_W = 8
) ();
    logic                in_valid;
    logic [WIDTH-1:0]    code_in;
    logic                clr_err;
    logic [IDX_W-1:0]    idx_out;
    logic                idx_valid;
    logic                illegal;
    logic                seq_err;
    logic                wrap;
    logic                locked;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output in_valid, code_in, clr_err,
        input  idx_out, idx_valid, illegal, seq_err, wrap, locked, err_count
    );

    modport slave (
        input  in_valid, code_in, clr_err,
        output idx_out, idx_valid, illegal, seq_err, wrap, locked, err_count
    );
endinterface

// File: rtl/johnson_seq_monitor.sv
// Johnson code decoder and sequence checker: locks onto a twisted-ring stream,
// flags illegal codes and out-of-order steps, and keeps a saturating error count.
module johnson_seq_monitor #(
    parameter int WIDTH      = 5,
    parameter int IDX_W      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2,
    parameter int ERRCNT_W   = 8
) (
    input logic                  clk,
    input logic                  clear,
    johnson_seq_monitor_if.slave bus
);
    localparam int STATES = 2 * WIDTH;
    localparam int GC_W   = $clog2(LOCK_COUNT + 1);
    localparam int BC_W   = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev_code;
    logic [GC_W-1:0]  good_cnt;
    logic [BC_W-1:0]  bad_cnt;

    logic [WIDTH-1:0] code;
    logic [WIDTH-1:0] succ_code;
    logic [IDX_W-1:0] code_idx;
    logic             legal;
    logic             good;
    logic             hold;
    logic             wrap_step;
    int               trans;
    int               ones;

    // A Johnson code is a single run of ones against a run of zeros, so adjacent
    // bits may differ at most once across the word.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        code  = bus.code_in;
        trans = 0;
        ones  = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (code[i] != code[i+1]) trans++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            ones += int'(code[i]);
        end
        legal = (trans <= 1);
        if (code[0] || code == '0) code_idx = IDX_W'(ones);
        else                       code_idx = IDX_W'(STATES - ones);

        succ_code = {prev_code[WIDTH-2:0], ~prev_code[WIDTH-1]};
        good      = legal && (code == succ_code);
        hold      = legal && (code == prev_code);
        // The only good step landing on all-zeros comes from the last state.
        wrap_step = good && (code == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state         <= ST_HUNT;
            prev_code     <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            bus.idx_out   <= '0;
            bus.idx_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.seq_err   <= 1'b0;
            bus.wrap      <= 1'b0;
            bus.locked    <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.idx_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.seq_err   <= 1'b0;
            bus.wrap      <= 1'b0;
            if (bus.clr_err) bus.err_count <= '0;

            if (bus.in_valid) begin
                if (legal) begin
                    bus.idx_out   <= code_idx;
                    bus.idx_valid <= 1'b1;
                end else begin
                    bus.illegal <= 1'b1;
                end

                unique case (state)
                    ST_HUNT: begin
                        if (legal) begin
                            prev_code <= code;
                            good_cnt  <= '0;
                            state     <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        bus.wrap <= wrap_step;
                        if (!legal) begin
                            state <= ST_HUNT;
                        end else if (good) begin
                            prev_code <= code;
                            if (good_cnt == GC_W'(LOCK_COUNT - 1)) begin
                                good_cnt   <= '0;
                                bad_cnt    <= '0;
                                state      <= ST_LOCKED;
                                bus.locked <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else if (!hold) begin
                            prev_code <= code;
                            good_cnt  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        bus.wrap <= wrap_step;
                        if (good) begin
                            prev_code <= code;
                            bad_cnt   <= '0;
                        end else if (!hold) begin
                            bus.seq_err <= 1'b1;
                            // A simultaneous clear wins and this error is dropped.
                            if (!bus.clr_err && bus.err_count != '1)
                                bus.err_count <= bus.err_count + 1'b1;
                            if (legal) prev_code <= code;
                            if (bad_cnt == BC_W'(ERR_LIMIT - 1)) begin
                                bad_cnt    <= '0;
                                good_cnt   <= '0;
                                state      <= ST_HUNT;
                                bus.locked <= 1'b0;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_HUNT;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Self-checking bench for johnson_seq_monitor: directed vector table, hand-written
// corner sequences and randomized traffic against an index-based reference model.
module tb_johnson_seq_monitor;
    localparam int W      = 5;
    localparam int STATES = 2 * W;
    localparam int LOCKN  = 3;
    localparam int ERRLIM = 2;

    logic clk = 1'b0;
    logic clear;

    johnson_seq_monitor_if #(.WIDTH(W), .IDX_W(4), .ERRCNT_W(8)) bus ();

    johnson_seq_monitor #(
        .WIDTH(W), .IDX_W(4), .LOCK_COUNT(LOCKN), .ERR_LIMIT(ERRLIM), .ERRCNT_W(8)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] code;
        logic       clr;
        logic [3:0] idx;
        logic       iv;
        logic       ill;
        logic       se;
        logic       wr;
        logic       lk;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state (mode 0 = hunt, 1 = sync, 2 = locked; prev as state index).
    int         m_mode, m_prev, m_gc, m_bc;
    logic [3:0] e_idx;
    logic       e_iv, e_ill, e_se, e_wr, e_lk;
    logic [7:0] e_ec;

    // The i-th legal code: i low ones filling up, then zeros shifting in from the bottom.
    function automatic logic [4:0] jcode(input int i);
        int all_ones = (1 << W) - 1;
        if (i <= W) return 5'((1 << i) - 1);
        return 5'(all_ones & ~((1 << (i - W)) - 1));
    endfunction

    function automatic int lookup(input logic [4:0] c);
        for (int i = 0; i < STATES; i++) if (jcode(i) == c) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] idx, input logic iv,
                             input logic ill, input logic se, input logic wr,
                             input logic lk, input logic [7:0] ec);
        check({tag, ".idx_out"},   32'(bus.idx_out),   32'(idx));
        check({tag, ".idx_valid"}, 32'(bus.idx_valid), 32'(iv));
        check({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
        check({tag, ".seq_err"},   32'(bus.seq_err),   32'(se));
        check({tag, ".wrap"},      32'(bus.wrap),      32'(wr));
        check({tag, ".locked"},    32'(bus.locked),    32'(lk));
        check({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
    endtask

    task automatic add(input logic v, input logic [4:0] code, input logic clr,
                       input logic [3:0] idx, input logic iv, input logic ill, input logic se,
                       input logic wr, input logic lk, input logic [7:0] ec);
        vec_t t;
        t.v = v; t.code = code; t.clr = clr; t.idx = idx; t.iv = iv;
        t.ill = ill; t.se = se; t.wr = wr; t.lk = lk; t.ec = ec;
        tbl.push_back(t);
    endtask

    task automatic apply(input logic v, input logic [4:0] c, input logic clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.code_in  = c;
        bus.clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_mode = 0; m_prev = 0; m_gc = 0; m_bc = 0;
        e_idx = '0; e_iv = 0; e_ill = 0; e_se = 0; e_wr = 0; e_lk = 0; e_ec = '0;
    endtask

    task automatic model_step(input logic v, input logic [4:0] c, input logic clr);
        int  li;
        bit  good, hold;
        e_iv = 0; e_ill = 0; e_se = 0; e_wr = 0;
        if (clr) e_ec = '0;
        if (v) begin
            li   = lookup(c);
            good = (li >= 0) && (li == (m_prev + 1) % STATES);
            hold = (li >= 0) && (li == m_prev);
            if (li >= 0) begin e_idx = 4'(li); e_iv = 1; end
            else e_ill = 1;
            case (m_mode)
                0: if (li >= 0) begin m_prev = li; m_gc = 0; m_mode = 1; end
                1: begin
                    if (li < 0) m_mode = 0;
                    else if (good) begin
                        e_wr = (li == 0); m_prev = li; m_gc++;
                        if (m_gc == LOCKN) begin m_mode = 2; m_bc = 0; end
                    end else if (!hold) begin m_gc = 0; m_prev = li; end
                end
                default: begin
                    if (good) begin e_wr = (li == 0); m_prev = li; m_bc = 0; end
                    else if (!hold) begin
                        e_se = 1;
                        if (!clr && e_ec != 8'hff) e_ec = e_ec + 8'd1;
                        if (li >= 0) m_prev = li;
                        m_bc++;
                        if (m_bc == ERRLIM) m_mode = 0;
                    end
                end
            endcase
        end
        e_lk = (m_mode == 2);
    endtask

    initial begin
        int cur;
        bus.in_valid = 1'b0;
        bus.code_in  = '0;
        bus.clr_err  = 1'b0;
        clear        = 1'b1;
        #12;
        check_all("reset", 4'd0, 0, 0, 0, 0, 0, 8'd0);
        clear = 1'b0;

        // Full cycle with lock and wrap, illegal injection, holds, double skip.
        add(1, 5'b00000, 0, 4'd0, 1, 0, 0, 0, 0, 8'd0);
        add(1, 5'b00001, 0, 4'd1, 1, 0, 0, 0, 0, 8'd0);
        add(1, 5'b00011, 0, 4'd2, 1, 0, 0, 0, 0, 8'd0);
        add(1, 5'b00111, 0, 4'd3, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b01111, 0, 4'd4, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b11111, 0, 4'd5, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b11110, 0, 4'd6, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b11100, 0, 4'd7, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b11000, 0, 4'd8, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b10000, 0, 4'd9, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00000, 0, 4'd0, 1, 0, 0, 1, 1, 8'd0);
        add(0, 5'b00000, 0, 4'd0, 0, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00101, 0, 4'd0, 0, 1, 1, 0, 1, 8'd1);
        add(1, 5'b00001, 0, 4'd1, 1, 0, 0, 0, 1, 8'd1);
        add(0, 5'b00000, 1, 4'd1, 0, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00011, 0, 4'd2, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00111, 0, 4'd3, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00111, 0, 4'd3, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00111, 0, 4'd3, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00111, 0, 4'd3, 1, 0, 0, 0, 1, 8'd0);
        add(1, 5'b00011, 0, 4'd2, 1, 0, 1, 0, 1, 8'd1);
        add(1, 5'b11000, 0, 4'd8, 1, 0, 1, 0, 0, 8'd2);
        add(0, 5'b00000, 0, 4'd8, 0, 0, 0, 0, 0, 8'd2);
        add(1, 5'b00001, 0, 4'd1, 1, 0, 0, 0, 0, 8'd2);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].code, tbl[i].clr);
            check_all($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].iv, tbl[i].ill,
                      tbl[i].se, tbl[i].wr, tbl[i].lk, tbl[i].ec);
        end

        // Saturation: alternate illegal / correct successor while locked.
        do_reset();
        for (int i = 0; i <= LOCKN; i++) apply(1, jcode(i), 0);
        check("sat.lock", 32'(bus.locked), 32'd1);
        cur = LOCKN;
        for (int i = 0; i < 300; i++) begin
            apply(1, 5'b01010, 0);
            if (i == 254) check("sat.count254", 32'(bus.err_count), 32'd255);
            cur = (cur + 1) % STATES;
            apply(1, jcode(cur), 0);
        end
        check("sat.hold", 32'(bus.err_count), 32'd255);
        check("sat.locked", 32'(bus.locked), 32'd1);
        apply(1, 5'b00101, 1);
        check("clr_prio.seq_err", 32'(bus.seq_err), 32'd1);
        check("clr_prio.err_count", 32'(bus.err_count), 32'd0);

        // Asynchronous clear mid-lock with in_valid high, then a full relock.
        cur = (cur + 1) % STATES;
        apply(1, jcode(cur), 0);
        check("pre_clear.locked", 32'(bus.locked), 32'd1);
        @(negedge clk);
        cur = (cur + 1) % STATES;
        bus.in_valid = 1'b1;
        bus.code_in  = jcode(cur);
        #2 clear = 1'b1;
        #1 check_all("async_clear", 4'd0, 0, 0, 0, 0, 0, 8'd0);
        @(posedge clk);
        #1 check_all("clear_held", 4'd0, 0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i <= LOCKN; i++) begin
            apply(1, jcode(i), 0);
            check($sformatf("relock%0d", i), 32'(bus.locked), (i == LOCKN) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic       v, clr;
            logic [4:0] c;
            int         r;
            v   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 19) == 0);
            r   = $urandom_range(0, 99);
            if (r < 60)      c = jcode((m_prev + 1) % STATES);
            else if (r < 72) c = jcode(m_prev);
            else if (r < 87) c = jcode($urandom_range(0, STATES - 1));
            else             c = 5'($urandom);
            apply(v, c, clr);
            model_step(v, c, clr);
            check_all($sformatf("rnd%0d", n), e_idx, e_iv, e_ill, e_se, e_wr, e_lk, e_ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
